addr_parser: RTL and testbench

ADDR_PARSER -- requirements
Module: addr_parser

---
 rtl/addr_parser.sv | 159 +++++++++++++++
 tb/tb_addr_parser.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_parser.sv
// Address header parser: header bytes (start + block), end byte, range check.
// Optional idle timeout in HDR/ENDB when ADDR_PARSER_TIMEOUT_EN is defined.
module addr_parser #(
   parameter int OFFSET_W    = 6,
   parameter int BLOCK_W     = 10,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic                enable,
   input  logic                byte_valid,
   input  logic [7:0]          addr_byte,
   input  logic                done,
   input  logic                abort,
   output logic [OFFSET_W-1:0] start_address,
   output logic [OFFSET_W-1:0] end_address,
   output logic [BLOCK_W-1:0]  block_address,
   output logic [OFFSET_W:0]   rollover_value,
   output logic                addr_ready,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [2:0]          parser_state
);

   localparam int HDR_BYTES = (OFFSET_W + BLOCK_W + 7) / 8;
   localparam int HDR_W     = HDR_BYTES * 8;
   localparam logic [2:0] LAST_BYTE = 3'(HDR_BYTES - 1);
   localparam logic [OFFSET_W:0] ONE = (OFFSET_W+1)'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      ENDB  = 3'd2,
      CHECK = 3'd3,
      READY = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [HDR_W-1:0]    hdr_q, hdr_d;
   logic [OFFSET_W-1:0] start_q, start_d;
   logic [OFFSET_W-1:0] end_q, end_d;
   logic [BLOCK_W-1:0]  block_q, block_d;
   logic [1:0]          ecode_q, ecode_d;
`ifdef ADDR_PARSER_TIMEOUT_EN
   logic [15:0]         tmo_q, tmo_d;
`endif

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hdr_q   <= '0;
         start_q <= '0;
         end_q   <= '0;
         block_q <= '0;
         ecode_q <= '0;
`ifdef ADDR_PARSER_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         start_q <= start_d;
         end_q   <= end_d;
         block_q <= block_d;
         ecode_q <= ecode_d;
`ifdef ADDR_PARSER_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      start_d = start_q;
      end_d   = end_q;
      block_d = block_q;
      ecode_d = ecode_q;
`ifdef ADDR_PARSER_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = HDR;
               cnt_d   = '0;
               hdr_d   = '0;
`ifdef ADDR_PARSER_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         HDR: begin
            if (byte_valid) begin
               for (int k = 0; k < HDR_BYTES; k++) begin
                  if (cnt_q == 3'(k)) hdr_d[k*8 +: 8] = addr_byte;
               end
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == LAST_BYTE) begin
                  state_d = ENDB;
                  start_d = hdr_d[OFFSET_W-1:0];
                  block_d = hdr_d[OFFSET_W+BLOCK_W-1:OFFSET_W];
               end
            end
         end
         ENDB: begin
            if (byte_valid) begin
               end_d   = addr_byte[OFFSET_W-1:0];
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (end_q < start_q) begin
               state_d = ERR;
               ecode_d = 2'b01;
            end else begin
               state_d = READY;
            end
         end
         READY: if (done) state_d = IDLE;
         ERR:   if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef ADDR_PARSER_TIMEOUT_EN
      if (state_q == HDR || state_q == ENDB) begin
         tmo_d = byte_valid ? 16'd0 : tmo_q + 16'd1;
         if (!byte_valid && tmo_q == 16'(TIMEOUT_CYC - 1)) begin
            state_d = ERR;
            ecode_d = 2'b10;
         end
      end
`endif
      // abort beats any capture made this cycle
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         start_d = start_q;
         end_d   = end_q;
         block_d = block_q;
      end
      if (state_d == IDLE) ecode_d = 2'b00;
   end

   always_comb begin
      start_address  = start_q;
      end_address    = end_q;
      block_address  = block_q;
      rollover_value = {1'b0, end_q} - {1'b0, start_q} + ONE;
      addr_ready     = (state_q == READY);
      err            = (state_q == ERR);
      err_code       = ecode_q;
      parser_state   = state_q;
   end

endmodule

// File: tb/tb_addr_parser.sv
// Scoreboard bench for addr_parser: random and directed parses checked
// against an arithmetic model; a negedge monitor pops expected results.
module tb_addr_parser;

   localparam int OW = 6;
   localparam int BW = 10;
   localparam int TO = 255;

   typedef struct {
      int kind;
      int st;
      int en;
      int blk;
      int roll;
      int cyc;
   } exp_t;

   logic          clk, n_reset, enable, byte_valid, done, abort;
   logic [7:0]    addr_byte;
   logic [OW-1:0] start_address, end_address;
   logic [BW-1:0] block_address;
   logic [OW:0]   rollover_value;
   logic          addr_ready, err;
   logic [1:0]    err_code;
   logic [2:0]    parser_state;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   drv_cyc = 0;
   int   m_start = 0, m_end = 0, m_block = 0;
   bit   prev_seen = 0;
   exp_t q[$];
   exp_t mon_e;

   addr_parser dut (
      .clk(clk), .n_reset(n_reset), .enable(enable),
      .byte_valid(byte_valid), .addr_byte(addr_byte),
      .done(done), .abort(abort),
      .start_address(start_address), .end_address(end_address),
      .block_address(block_address), .rollover_value(rollover_value),
      .addr_ready(addr_ready), .err(err), .err_code(err_code),
      .parser_state(parser_state)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // monitor: every rising addr_ready/err is one DUT response
   always @(negedge clk) begin
      if (!n_reset) begin
         prev_seen = 0;
      end else begin
         if ((addr_ready || err) && !prev_seen) begin
            if (q.size() == 0) begin
               chk("unexpected_response", 1, 0);
            end else begin
               mon_e = q.pop_front();
               chk("resp_ready", addr_ready, mon_e.kind == 0);
               chk("resp_err", err, mon_e.kind != 0);
               chk("resp_err_code", err_code, mon_e.kind);
               chk("resp_latency", cyc, mon_e.cyc);
               if (mon_e.kind != 2) begin
                  chk("resp_start", start_address, mon_e.st);
                  chk("resp_end", end_address, mon_e.en);
                  chk("resp_block", block_address, mon_e.blk);
               end
               if (mon_e.kind == 0)
                  chk("resp_rollover", rollover_value, mon_e.roll);
            end
         end
         prev_seen = addr_ready || err;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, input bit rnd_en);
      repeat (gap) begin
         @(posedge clk); #1;
         byte_valid = 0;
         addr_byte  = 8'($urandom);
         enable     = rnd_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(posedge clk); #1;
      byte_valid = 1;
      addr_byte  = b;
      enable     = 0;
      drv_cyc    = cyc;
   endtask

   task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1, input int g1);
      int hdr;
      @(posedge clk); #1;
      enable = 1;
      byte_valid = 0;
      send_byte(b0, 0, 0);
      send_byte(b1, g1, 1);
      hdr = int'(b0) + 256 * int'(b1);
      m_start = hdr % (1 << OW);
      m_block = (hdr / (1 << OW)) % (1 << BW);
   endtask

   task automatic finish_out(input int bound, input bit poke);
      bit got = 0;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clk);
         if (addr_ready || err) got = 1;
      end
      chk("response_seen", got, 1);
      if (poke && addr_ready) begin
         repeat (3) begin
            @(posedge clk); #1;
            byte_valid = 1;
            addr_byte  = 8'($urandom);
         end
         @(posedge clk); #1;
         byte_valid = 0;
         @(negedge clk);
         chk("ready_hold_state", parser_state, 4);
         chk("ready_hold_end", end_address, m_end);
      end
      @(posedge clk); #1;
      done = 1;
      @(posedge clk); #1;
      done = 0;
      @(negedge clk);
      chk("idle_state", parser_state, 0);
      chk("idle_err", err, 0);
      chk("idle_ready", addr_ready, 0);
      chk("idle_err_code", err_code, 0);
      chk("idle_start", start_address, m_start);
      chk("idle_end", end_address, m_end);
      chk("idle_block", block_address, m_block);
   endtask

   task automatic send_end(input logic [7:0] b2, input int g2, input bit poke);
      exp_t e;
      send_byte(b2, g2, 1);
      e.st   = m_start;
      e.blk  = m_block;
      e.en   = int'(b2) % (1 << OW);
      e.kind = (e.en < e.st) ? 1 : 0;
      e.roll = e.en - e.st + 1;
      e.cyc  = drv_cyc + 2;
      q.push_back(e);
      m_end = e.en;
      @(posedge clk); #1;
      byte_valid = 0;
      enable = 0;
      finish_out(20, poke);
   endtask

   task automatic run(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input int g1, input int g2,
                      input bit poke);
      send_hdr(b0, b1, g1);
      send_end(b2, g2, poke);
   endtask

   initial begin
      n_reset = 0;
      enable = 0;
      byte_valid = 0;
      addr_byte = 0;
      done = 0;
      abort = 0;
      repeat (2) @(negedge clk);
      chk("rst_state", parser_state, 0);
      chk("rst_start", start_address, 0);
      chk("rst_end", end_address, 0);
      chk("rst_block", block_address, 0);
      chk("rst_rollover", rollover_value, 1);
      chk("rst_ready", addr_ready, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      n_reset = 1;

      run(8'h85, 8'h3C, 8'h2A, 0, 0, 1);
      run(8'h10, 8'h00, 8'h05, 0, 0, 0);
      run(8'h3F, 8'h00, 8'h3F, 0, 0, 0);
      run(8'h00, 8'h00, 8'h3F, 0, 0, 0);

      // abort after first header byte, colliding with a byte_valid
      @(posedge clk); #1;
      enable = 1;
      send_byte(8'h55, 0, 0);
      @(posedge clk); #1;
      abort = 1;
      byte_valid = 1;
      addr_byte = 8'hAA;
      @(posedge clk); #1;
      abort = 0;
      byte_valid = 0;
      @(negedge clk);
      chk("abort_state", parser_state, 0);
      chk("abort_start", start_address, m_start);
      chk("abort_end", end_address, m_end);
      chk("abort_block", block_address, m_block);
      run(8'h01, 8'h02, 8'h03, 0, 0, 0);

`ifdef ADDR_PARSER_TIMEOUT_EN
      begin
         exp_t e;
         send_hdr(8'h85, 8'h3C, 0);
         e = '{kind: 2, st: 0, en: 0, blk: 0, roll: 0, cyc: drv_cyc + 1 + TO};
         q.push_back(e);
         @(posedge clk); #1;
         byte_valid = 0;
         finish_out(TO + 20, 0);
      end
      send_hdr(8'h85, 8'h3C, 0);
      send_end(8'h2A, TO - 1, 0);
`else
      send_hdr(8'h12, 8'h34, 0);
      @(posedge clk); #1;
      byte_valid = 0;
      repeat (300) @(posedge clk);
      @(negedge clk);
      chk("no_timeout_state", parser_state, 2);
      chk("no_timeout_err", err, 0);
      send_end(8'h3F, 0, 0);
`endif

      // asynchronous reset while waiting in ENDB
      send_hdr(8'h85, 8'h3C, 0);
      @(posedge clk); #1;
      byte_valid = 0;
      @(negedge clk);
      chk("pre_reset_state", parser_state, 2);
      #2 n_reset = 0;
      #1;
      chk("async_rst_state", parser_state, 0);
      chk("async_rst_start", start_address, 0);
      chk("async_rst_block", block_address, 0);
      chk("async_rst_rollover", rollover_value, 1);
      m_start = 0;
      m_end = 0;
      m_block = 0;
      @(negedge clk);
      n_reset = 1;

      for (int i = 0; i < 40; i++) begin
         run(8'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog expired t=%0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
